// File: rtl/mem_wait_responder.sv
// Slow data-memory model: one request at a time, LATENCY wait states, valid/ready response.
// Optional MEM_ACCESS_CNT_EN adds rd_count/wr_count/err_count handshake counters.
//
// state  | meaning
// IDLE   | req_ready=1, waiting for req_valid
// WAIT   | request accepted, counting down wait states
// RESP   | rsp_valid=1, holding response until rsp_ready
module mem_wait_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
`ifdef MEM_ACCESS_CNT_EN
  ,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] err_count
`endif
);

  localparam int unsigned AW          = $clog2(DEPTH_WORDS);
  localparam logic [31:0] DEPTH_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  LAT         = 4'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic        r_busy;
  logic [3:0]  r_cnt;
  logic [31:0] r_hold_rdata;
  logic        r_hold_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [31:0]   w_offset;
  logic          w_err;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rdata;
  logic [31:0]   w_rsp_data;
  logic          w_accept;
  logic          w_rsp_hs;

  // Underflow shows up as req_addr below the base before the subtraction wraps.
  assign w_offset   = req_addr - BASE_ADDR;
  assign w_err      = (req_addr[1:0] != 2'b00) | (req_addr < BASE_ADDR) | (w_offset >= DEPTH_BYTES);
  assign w_idx      = w_offset[AW+1:2];
  assign w_rdata    = r_mem[w_idx];
  assign w_rsp_data = (w_err | req_we) ? 32'h0 : w_rdata;
  assign w_accept   = r_req_ready & req_valid;
  assign w_rsp_hs   = r_rsp_valid & rsp_ready;

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;

  // Writes commit at acceptance, so a later reset cannot undo them.
  always_ff @(posedge CLK) begin
    if (!RST && w_accept && req_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be[b]) r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= 32'h0;
      r_rsp_err    <= 1'b0;
      r_busy       <= 1'b0;
      r_cnt        <= 4'd0;
      r_hold_rdata <= 32'h0;
      r_hold_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_hold_rdata <= w_rsp_data;
            r_hold_err   <= w_err;
            r_cnt        <= LAT;
            r_req_ready  <= 1'b0;
            r_busy       <= 1'b1;
            if (LATENCY == 0) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_rsp_data;
              r_rsp_err   <= w_err;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd1) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_hold_rdata;
            r_rsp_err   <= r_hold_err;
            r_cnt       <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef MEM_ACCESS_CNT_EN
  logic        r_we;
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;
  logic [31:0] r_err_count;

  assign rd_count  = r_rd_count;
  assign wr_count  = r_wr_count;
  assign err_count = r_err_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_we        <= 1'b0;
      r_rd_count  <= 32'h0;
      r_wr_count  <= 32'h0;
      r_err_count <= 32'h0;
    end else begin
      if (w_accept) r_we <= req_we;
      if (w_rsp_hs) begin
        if (r_rsp_err)  r_err_count <= r_err_count + 32'd1;
        else if (r_we)  r_wr_count  <= r_wr_count + 32'd1;
        else            r_rd_count  <= r_rd_count + 32'd1;
      end
    end
  end
`else
  logic w_unused_hs;
  assign w_unused_hs = w_rsp_hs;
`endif

endmodule

// File: tb/tb_mem_wait_responder.sv
// Randomized bench for mem_wait_responder: two instances (slow/zero-based, fast/offset base)
// checked against a byte-array reference model with spec-level latency and error rules.
module tb_mem_wait_responder;

  localparam int          LAT0  = 2;
  localparam int          LAT1  = 0;
  localparam int          DEP0  = 64;
  localparam int          DEP1  = 16;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_0100;

  logic        CLK = 1'b0;
  logic        RST       [2];
  logic        req_valid [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_ready [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic        busy      [2];
`ifdef MEM_ACCESS_CNT_EN
  logic [31:0] rd_count  [2];
  logic [31:0] wr_count  [2];
  logic [31:0] err_count [2];
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mdl [2][64];
  int unsigned m_rd [2];
  int unsigned m_wr [2];
  int unsigned m_er [2];

  always #5 CLK = ~CLK;

  mem_wait_responder #(.DEPTH_WORDS(DEP0), .LATENCY(LAT0), .BASE_ADDR(BASE0)) u_dut0 (
    .CLK(CLK), .RST(RST[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]), .busy(busy[0])
`ifdef MEM_ACCESS_CNT_EN
    , .rd_count(rd_count[0]), .wr_count(wr_count[0]), .err_count(err_count[0])
`endif
  );

  mem_wait_responder #(.DEPTH_WORDS(DEP1), .LATENCY(LAT1), .BASE_ADDR(BASE1)) u_dut1 (
    .CLK(CLK), .RST(RST[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]), .busy(busy[1])
`ifdef MEM_ACCESS_CNT_EN
    , .rd_count(rd_count[1]), .wr_count(wr_count[1]), .err_count(err_count[1])
`endif
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic int dep_of(input int d);
    return (d == 0) ? DEP0 : DEP1;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? BASE0 : BASE1;
  endfunction

  function automatic logic exp_err(input int d, input logic [31:0] addr);
    logic [31:0] b;
    b = base_of(d);
    return (addr[1:0] != 2'b00) || (addr < b) || ((addr - b) >= 32'(dep_of(d) * 4));
  endfunction

  function automatic logic [31:0] gen_addr(input int d);
    logic [31:0] b;
    int r;
    b = base_of(d);
    r = $urandom_range(0, 9);
    if (r == 0) return b + 32'(4 * $urandom_range(0, dep_of(d) - 1)) + 32'($urandom_range(1, 3));
    if (r == 1) return b + 32'(dep_of(d) * 4) + 32'(4 * $urandom_range(0, 15));
    if (r == 2 && b != 32'h0) return b - 32'(4 * $urandom_range(1, 8));
    if (r == 3) return 32'hFFFF_FFFC;
    return b + 32'(4 * $urandom_range(0, dep_of(d) - 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %08h exp %08h", tag, got, exp);
    end
  endtask

  // One full transaction; bp = cycles rsp_ready is held low once the response shows up.
  task automatic txn(input int d, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int bp);
    logic        err;
    logic [31:0] exp;
    int          k;
    int          idx;
    err = exp_err(d, addr);
    exp = 32'h0;
    if (!err) begin
      idx = int'((addr - base_of(d)) >> 2);
      if (we) begin
        for (int b = 0; b < 4; b++) if (be[b]) mdl[d][idx][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        exp = mdl[d][idx];
      end
    end
    @(negedge CLK);
    chk("idle_ready", 32'(req_ready[d]), 32'd1);
    chk("idle_busy", 32'(busy[d]), 32'd0);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = be;
    rsp_ready[d] = (bp == 0);
    @(negedge CLK);
    // Junk traffic while busy must be ignored; it would corrupt later reads otherwise.
    req_valid[d] = 1'($urandom_range(0, 1));
    req_we[d]    = 1'b1;
    req_addr[d]  = base_of(d) + 32'(4 * $urandom_range(0, dep_of(d) - 1));
    req_wdata[d] = $urandom;
    req_be[d]    = 4'hF;
    k = 1;
    while (!rsp_valid[d] && k < 40) begin
      chk("wait_ready", 32'(req_ready[d]), 32'd0);
      chk("wait_busy", 32'(busy[d]), 32'd1);
      @(negedge CLK);
      k++;
    end
    if (!rsp_valid[d]) begin
      chk("rsp_timeout", 32'd0, 32'd1);
    end else begin
      chk("rsp_latency", 32'(k), 32'(lat_of(d) + 1));
      chk("rsp_rdata", rsp_rdata[d], exp);
      chk("rsp_err", 32'(rsp_err[d]), 32'(err));
      chk("rsp_req_ready", 32'(req_ready[d]), 32'd0);
      for (int i = 0; i < bp; i++) begin
        @(negedge CLK);
        chk("bp_valid", 32'(rsp_valid[d]), 32'd1);
        chk("bp_rdata", rsp_rdata[d], exp);
        chk("bp_req_ready", 32'(req_ready[d]), 32'd0);
      end
      if (err) m_er[d]++;
      else if (we) m_wr[d]++;
      else m_rd[d]++;
    end
    rsp_ready[d] = 1'b1;
    @(negedge CLK);
    req_valid[d] = 1'b0;
    chk("post_ready", 32'(req_ready[d]), 32'd1);
    chk("post_valid", 32'(rsp_valid[d]), 32'd0);
  endtask

  task automatic reset_mid(input int d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int seen;
    if (we && !exp_err(d, addr)) mdl[d][int'((addr - base_of(d)) >> 2)] = wdata;
    @(negedge CLK);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_be[d]    = 4'hF;
    rsp_ready[d] = 1'b1;
    @(negedge CLK);
    req_valid[d] = 1'b0;
    chk("rm_busy", 32'(busy[d]), 32'd1);
    RST[d] = 1'b1;
    @(negedge CLK);
    RST[d] = 1'b0;
    m_rd[d] = 0; m_wr[d] = 0; m_er[d] = 0;
    chk("rm_valid", 32'(rsp_valid[d]), 32'd0);
    chk("rm_ready", 32'(req_ready[d]), 32'd1);
    chk("rm_idle", 32'(busy[d]), 32'd0);
    chk("rm_rdata", rsp_rdata[d], 32'h0);
    seen = 0;
    repeat (lat_of(d) + 4) begin
      @(negedge CLK);
      if (rsp_valid[d]) seen++;
    end
    chk("rm_no_rsp", 32'(seen), 32'd0);
  endtask

`ifdef MEM_ACCESS_CNT_EN
  task automatic chk_counts(input int d);
    chk("rd_count", rd_count[d], m_rd[d]);
    chk("wr_count", wr_count[d], m_wr[d]);
    chk("err_count", err_count[d], m_er[d]);
  endtask
`endif

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      RST[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'h0;
      req_wdata[d] = 32'h0; req_be[d] = 4'h0; rsp_ready[d] = 1'b0;
      m_rd[d] = 0; m_wr[d] = 0; m_er[d] = 0;
    end
    repeat (3) @(negedge CLK);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 32'(req_ready[d]), 32'd1);
      chk("rst_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_rdata", rsp_rdata[d], 32'h0);
      chk("rst_err", 32'(rsp_err[d]), 32'd0);
      chk("rst_busy", 32'(busy[d]), 32'd0);
`ifdef MEM_ACCESS_CNT_EN
      chk_counts(d);
`endif
      RST[d] = 1'b0;
    end

    for (int d = 0; d < 2; d++)
      for (int w = 0; w < dep_of(d); w++)
        txn(d, 1'b1, base_of(d) + 32'(4 * w), $urandom, 4'hF, 0);

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    txn(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    txn(0, 1'b0, 32'h12, 32'h0, 4'h0, 0);
    txn(0, 1'b0, 32'h100, 32'h0, 4'h0, 0);
    txn(0, 1'b1, 32'h100, 32'h55, 4'hF, 0);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    txn(0, 1'b1, 32'h14, 32'h12345678, 4'h0, 0);
    txn(0, 1'b0, 32'h14, 32'h0, 4'h0, 0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5);
    txn(0, 1'b0, 32'hFC, 32'h0, 4'h0, 0);

    reset_mid(0, 1'b0, 32'h20, 32'h0);
    reset_mid(0, 1'b1, 32'h24, 32'hCAFEF00D);
    txn(0, 1'b0, 32'h24, 32'h0, 4'h0, 0);

    txn(1, 1'b1, 32'h108, 32'hA5A5_5A5A, 4'hF, 0);
    txn(1, 1'b0, 32'h108, 32'h0, 4'h0, 0);
    txn(1, 1'b0, 32'hFC, 32'h0, 4'h0, 0);
    txn(1, 1'b0, 32'h140, 32'h0, 4'h0, 0);
    txn(1, 1'b0, 32'h13C, 32'h0, 4'h0, 0);
    txn(1, 1'b0, 32'h101, 32'h0, 4'h0, 2);

    for (int i = 0; i < 60; i++) begin
      for (int d = 0; d < 2; d++)
        txn(d, 1'($urandom_range(0, 1)), gen_addr(d), $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(0, 3));
    end

`ifdef MEM_ACCESS_CNT_EN
    chk_counts(0);
    chk_counts(1);
    @(negedge CLK);
    RST[0] = 1'b1;
    @(negedge CLK);
    RST[0] = 1'b0;
    m_rd[0] = 0; m_wr[0] = 0; m_er[0] = 0;
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    txn(0, 1'b1, 32'h4, 32'h1, 4'hF, 1);
    txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 0);
    txn(0, 1'b0, 32'h3, 32'h0, 4'h0, 0);
    txn(0, 1'b1, 32'h8, 32'h2, 4'h3, 0);
    txn(0, 1'b0, 32'h8, 32'h0, 4'h0, 2);
    chk("cnt_rd3", rd_count[0], 32'd3);
    chk("cnt_wr2", wr_count[0], 32'd2);
    chk("cnt_err1", err_count[0], 32'd1);
    @(negedge CLK);
    RST[0] = 1'b1;
    @(negedge CLK);
    RST[0] = 1'b0;
    chk("cnt_rst_rd", rd_count[0], 32'd0);
    chk("cnt_rst_wr", wr_count[0], 32'd0);
    chk("cnt_rst_err", err_count[0], 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_wait_responder.md
Name: mem_wait_responder

Overview:
- Data-memory responder for the multicycle CPU's load/store path; sits where the core's data memory sits today, on the far side of the address/data interface.
- Accepts one request at a time (read or byte-masked write), inserts a programmable number of wait states, then returns a response under a valid/ready handshake.
- Gives verification a realistic slow-memory model and gives the next CPU revision a stall source to design against.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored; power of two, 4..1024.
- LATENCY, 2, wait cycles between request acceptance and rsp_valid assertion; 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; word-aligned.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address.
- req_wdata  input  32  write data.
- req_be  input  4  byte enables; bit n selects bits 8n+7:8n.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  read data; 0 for writes and errors.
- rsp_err  output  1  request was rejected (misaligned or out of range).
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: the synchronous active-high reset on CLK/RST is already decided. Reset drives state to IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0 and the wait counter to 0. Memory contents are not cleared.
- Reset mid-operation: an in-flight request is discarded and no response is produced. A write that was accepted before RST is still committed if it was already in WAIT, because commit happens at acceptance (see below).
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. A request is accepted on the edge where req_valid and req_ready are both 1. On acceptance, latch we/addr/wdata/be and load the counter with LATENCY.
    - If LATENCY==0, go directly to RESP.
    - Otherwise go to WAIT.
  - WAIT: req_ready=0. The counter decrements each cycle. When the counter reaches 1, the next state is RESP. rsp_valid therefore first rises LATENCY+1 cycles after the acceptance edge (LATENCY=0 gives a 1-cycle response).
  - RESP: rsp_valid=1 with rsp_rdata/rsp_err stable until the edge where rsp_ready=1, then return to IDLE. Back-to-back operation: req_ready is 0 in RESP, so the next request can be accepted at the earliest in the cycle after the response handshake.
- Error check, done at acceptance:
  - err if req_addr[1:0]!=0.
  - err if (req_addr-BASE_ADDR) is negative (unsigned underflow) or >= DEPTH_WORDS*4.
  - An errored request performs no memory access and returns rdata=0, err=1.
- Write commit: on the acceptance edge, each byte with be[n]=1 is updated. be=4'b0000 is a legal no-op write that still produces a response. A write response carries rdata=0, err=0.
- Read data: sampled from the array at acceptance, so it reflects all previously committed writes. It is held in a register until the response handshake.
- Word index is (req_addr-BASE_ADDR)[log2(DEPTH_WORDS*4)-1:2]. There is no wrap-around; out-of-range addresses error.
- Inputs that change while req_ready=0 are ignored.

Optional Feature:
- Macro: MEM_ACCESS_CNT_EN.
- Defined: adds output ports rd_count[31:0], wr_count[31:0] and err_count[31:0].
  - Each counter increments on the response handshake edge of a successful read, a successful write, or an errored request respectively.
  - The counters reset to 0 on RST and wrap at 2^32.
- Undefined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Write then read, LATENCY=2: write addr 0x10, data 0xDEADBEEF, be=4'hF, rsp_ready=1. Expect rsp_valid 3 cycles after acceptance with err=0 and rdata=0. Then read 0x10; expect rdata=0xDEADBEEF after 3 cycles.
- Byte enables: with word 0x10 = 0xDEADBEEF, write 0x11223344 with be=4'b0101. Reading 0x10 returns 0xDE22BE44.
- Errors: read addr 0x12 gives err=1, rdata=0. Read addr 0x100 (DEPTH_WORDS=64) gives err=1. Write 0x55 to 0x100 followed by a read of 0x0 shows word 0 unchanged.
- Backpressure: read response with rsp_ready held 0 for 5 cycles keeps rsp_valid=1 and rdata stable, with req_ready=0 throughout. req_ready returns to 1 the cycle after rsp_ready=1.
- Reset mid-operation: assert RST during WAIT of a read. Expect rsp_valid=0 and req_ready=1 the next cycle, and no response appears afterwards. With LATENCY=0, a read of the address just written responds 1 cycle after acceptance with the new data.
- MEM_ACCESS_CNT_EN: 3 reads, 2 writes and 1 error give rd_count=3, wr_count=2, err_count=1. Asserting RST clears all three to 0.
